// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: prescaled digit scan, glyph decode, blanking, dead time.
// Optional blinking is built when SEG_BLINK_EN is defined; otherwise blink_mask is ignored.
module seg_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned DEAD         = 64,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  page_sel,
    input  logic [5*DIGITS-1:0]   glyph_a,
    input  logic [5*DIGITS-1:0]   glyph_b,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            out,
    output logic [DIGITS-1:0]     selector,
    output logic                  frame_tick
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned DW = $clog2(DIGITS);

    logic [PW-1:0] pcnt;
    logic [DW-1:0] didx;
    logic          page_q;

    logic          slot_end_c;
    logic          frame_end_c;
    logic [4:0]    code_c;
    logic          blank_c;
    logic          blink_c;
    logic          blink_off_c;
    logic          dark_c;

    // Active-low a..g patterns; codes 16..31 are blank.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        seg = 7'b1111111;
        case (code)
            5'd0:    seg = 7'b0000001;
            5'd1:    seg = 7'b1001111;
            5'd2:    seg = 7'b0010010;
            5'd3:    seg = 7'b0000110;
            5'd4:    seg = 7'b1001100;
            5'd5:    seg = 7'b0100100;
            5'd6:    seg = 7'b0100000;
            5'd7:    seg = 7'b0001111;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0000100;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b1110000;
            5'd12:   seg = 7'b0010000;
            5'd13:   seg = 7'b1110001;
            5'd14:   seg = 7'b0100100;
            5'd15:   seg = 7'b1101010;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign slot_end_c  = (pcnt == PW'(REFRESH_DIV - 1));
    assign frame_end_c = slot_end_c && (didx == DW'(DIGITS - 1));

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            didx <= '0;
        end else if (slot_end_c) begin
            pcnt <= '0;
            didx <= frame_end_c ? '0 : didx + DW'(1);
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Page only changes on the frame boundary so a frame never mixes pages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_q <= 1'b0;
        end else if (frame_end_c) begin
            page_q <= page_sel;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] bcnt;
    logic          bphase;

    // Frame counter for blink half-periods; bphase=1 is the dark half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (frame_end_c) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                bcnt   <= '0;
                bphase <= ~bphase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    assign blink_off_c = bphase && blink_c;
`else
    logic unused_blink;

    assign blink_off_c  = 1'b0;
    assign unused_blink = ^{blink_c, blink_mask, 32'(BLINK_FRAMES)};
`endif

    // Select the current digit's glyph and mask bits.
    always_comb begin
        code_c  = 5'd31;
        blank_c = 1'b0;
        blink_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (didx == DW'(i)) begin
                code_c  = page_q ? glyph_b[5*i +: 5] : glyph_a[5*i +: 5];
                blank_c = blank_mask[i];
                blink_c = blink_mask[i];
            end
        end
    end

    assign dark_c = (pcnt < PW'(DEAD)) || blank_c || blink_off_c;

    // Registered segment/anode drive for the current slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out        <= 7'b1111111;
            selector   <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end_c;
            if (dark_c) begin
                out      <= 7'b1111111;
                selector <= '1;
            end else begin
                out      <= seg_decode(code_c);
                selector <= ~(DIGITS'(1) << didx);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected drive pushed per cycle from a frame-position model.
module tb_seg_scan_driver;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned DT = 1;
    localparam int unsigned BF = 2;
    localparam int unsigned FR = D * RD;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          page_sel;
    logic [19:0]   glyph_a;
    logic [19:0]   glyph_b;
    logic [3:0]    blank_mask;
    logic [3:0]    blink_mask;
    logic [6:0]    out;
    logic [3:0]    selector;
    logic          frame_tick;

    typedef struct packed {
        logic [6:0] o;
        logic [3:0] s;
        logic       t;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned t     = 0;
    logic        model_page = 1'b0;

    seg_scan_driver #(
        .DIGITS(D), .REFRESH_DIV(RD), .DEAD(DT), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .page_sel(page_sel),
        .glyph_a(glyph_a), .glyph_b(glyph_b),
        .blank_mask(blank_mask), .blink_mask(blink_mask),
        .out(out), .selector(selector), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        case (c)
            5'd0:  return 7'b0000001;
            5'd1:  return 7'b1001111;
            5'd2:  return 7'b0010010;
            5'd3:  return 7'b0000110;
            5'd4:  return 7'b1001100;
            5'd5:  return 7'b0100100;
            5'd6:  return 7'b0100000;
            5'd7:  return 7'b0001111;
            5'd8:  return 7'b0000000;
            5'd9:  return 7'b0000100;
            5'd10: return 7'b0001000;
            5'd11: return 7'b1110000;
            5'd12: return 7'b0010000;
            5'd13: return 7'b1110001;
            5'd14: return 7'b0100100;
            5'd15: return 7'b1101010;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, got, want);
        end
    endtask

    // One clock: predict the drive for model cycle t, then compare after the edge.
    task automatic step();
        int unsigned pos;
        int unsigned slot;
        int unsigned frame;
        bit          dark;
        exp_t        e;
        exp_t        g;
        logic [3:0]  one;
        one   = 4'b0001;
        pos   = t % RD;
        slot  = (t / RD) % D;
        frame = t / FR;
        dark  = (pos < DT) || blank_mask[slot] ||
                (BLINK_ON && ((frame / BF) % 2 == 1) && blink_mask[slot]);
        e.o = dark ? 7'b1111111
                   : ref_seg(model_page ? glyph_b[5*slot +: 5] : glyph_a[5*slot +: 5]);
        e.s = dark ? 4'b1111 : ~(one << slot);
        e.t = (pos == RD - 1) && (slot == D - 1);
        sbq.push_back(e);
        if (e.t) model_page = page_sel;
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk("out", 32'(out), 32'(g.o));
        chk("selector", 32'(selector), 32'(g.s));
        chk("frame_tick", 32'(frame_tick), 32'(g.t));
        t++;
    endtask

    int codes[7] = '{10, 11, 12, 13, 14, 15, 20};

    initial begin
        reset      = 1'b0;
        page_sel   = 1'b0;
        glyph_a    = {5'd4, 5'd3, 5'd2, 5'd1};
        glyph_b    = {5'd16, 5'd16, 5'd16, 5'd9};
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        #12;
        chk("rst_out", 32'(out), 32'h7f);
        chk("rst_selector", 32'(selector), 32'hf);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        t = 0;
        model_page = 1'b0;

        // Basic scan of digits 4,3,2,1.
        repeat (2 * FR) step();

        // Letter glyphs and an out-of-range code on digit 0.
        foreach (codes[i]) begin
            glyph_a[4:0] = 5'(codes[i]);
            repeat (FR) step();
        end
        glyph_a = {5'd4, 5'd3, 5'd2, 5'd1};

        // Digit 2 forced dark.
        blank_mask = 4'b0100;
        repeat (FR) step();
        blank_mask = 4'b0000;

        // Mid-frame page switch, then a short pulse that misses the wrap.
        repeat (6) step();
        page_sel = 1'b1;
        repeat (2 * FR) step();
        page_sel = 1'b0;
        repeat (4) step();
        page_sel = 1'b1;
        repeat (FR) step();
        page_sel = 1'b0;
        repeat (2 * FR) step();

        // Blink on digit 0 over several half-periods.
        blink_mask = 4'b0001;
        repeat (5 * FR) step();
        blink_mask = 4'b0000;

        // Asynchronous reset at cycle 7 of a frame.
        while (t % FR != 7) step();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'h7f);
        chk("async_rst_selector", 32'(selector), 32'hf);
        chk("async_rst_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        t = 0;
        model_page = 1'b0;
        sbq.delete();
        repeat (FR) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
